// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: grants the shared memory port to fetch or data, sequences a fixed-latency access
// and returns read data with a one-cycle done pulse.
module mem_port_arbiter #(
  parameter int AW = 16,
  parameter int DW = 24,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_nxt;
  logic owner, last_grant, we_q, win_d, grant;
  logic [3:0] cnt;
  // on a tie the data side wins unless it was granted last
  always_comb begin
    win_d = d_req & (~if_req | ~last_grant);
    grant = (state == IDLE) & (if_req | d_req);
    state_nxt = (state == IDLE)  ? (grant ? ISSUE : IDLE) :
                (state == ISSUE) ? WAIT :
                (state == WAIT)  ? ((cnt == 4'd1) ? DONE : WAIT) : IDLE;
    mem_en = state == ISSUE;
    mem_we = mem_en & we_q;
    if_done = (state == DONE) & ~owner;
    d_done = (state == DONE) & owner;
    busy = state != IDLE;
    stall = (if_req & ~if_done) | (d_req & ~d_done);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      owner <= 1'b0;
      last_grant <= 1'b0;
      we_q <= 1'b0;
      cnt <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      if_rdata <= '0;
      d_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner <= win_d;
        last_grant <= win_d;
        we_q <= win_d & d_we;
        mem_addr <= win_d ? d_addr : if_addr;
        if (win_d) mem_wdata <= d_wdata;
      end
      if (state == ISSUE) cnt <= 4'(LATENCY);
      if (state == WAIT) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1 && !we_q && owner) d_rdata <= mem_rdata;
        if (cnt == 4'd1 && !we_q && !owner) if_rdata <= mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed test of the memory port arbiter against a latency-accurate memory model.
module tb_mem_port_arbiter;
  localparam int AW = 16, DW = 24, LAT = 2;
  logic clk = 0, rst = 0;
  logic if_req = 0, d_req = 0, d_we = 0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic if_done, d_done, mem_en, mem_we, stall, busy;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem [0:65535];
  logic [DW-1:0] pipe [LAT];
  logic [DW-1:0] exp_if [$], exp_d [$];
  int en_cyc [$];
  logic [AW-1:0] en_addr [$];
  int cyc = 0, n_cmp = 0, n_err = 0;
  logic [DW-1:0] d_model = '0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall(stall), .busy(busy));

  always #5 clk = ~clk;

  // read data appears LAT cycles after the strobe; other slots carry junk so mistimed captures show
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr] : {8'hEE, 16'(cyc)};
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    if (if_done) begin
      if (exp_if.size() == 0) chk("if_done_unexpected", 1, 0);
      else chk("if_rdata", if_rdata, exp_if.pop_front());
    end
    if (d_done) begin
      if (exp_d.size() == 0) chk("d_done_unexpected", 1, 0);
      else chk("d_rdata", d_rdata, exp_d.pop_front());
    end
    if (mem_en) begin
      en_cyc.push_back(cyc);
      en_addr.push_back(mem_addr);
    end
    if (mem_we) chk("we_needs_en", mem_en, 1);
  end

  task automatic run(input int budget);
    for (int i = 0; i < budget && (if_req || d_req); i++) begin
      tick();
      if (if_done) if_req = 0;
      if (d_done) d_req = 0;
    end
    chk("run_timeout", {if_req, d_req}, 0);
  endtask

  initial begin
    int nd;
    for (int i = 0; i < 65536; i++) mem[i] = {8'h5A, 16'(i)};
    mem[16'h0010] = 24'hABCDEF;
    if_req = 1; d_req = 1; d_we = 1; d_addr = 16'h0040; d_wdata = 24'h654321; if_addr = 16'h0050;
    repeat (3) tick();
    chk("rst_ctrl", {mem_en, mem_we, busy, if_done, d_done}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", {if_rdata, d_rdata}, 0);
    rst = 1;
    exp_d.push_back(d_model);
    exp_if.push_back(24'h5A0050);
    tick();
    chk("first_grant_en", {mem_en, mem_we}, 2'b11);
    chk("first_grant_addr", mem_addr, 16'h0040);
    chk("first_grant_wdata", mem_wdata, 24'h654321);
    run(40);
    chk("store_mem0040", mem[16'h0040], 24'h654321);
    // load whose address changes mid-access
    d_we = 0; d_addr = 16'h0300; d_req = 1;
    d_model = 24'h5A0300;
    exp_d.push_back(d_model);
    tick();
    tick();
    d_addr = 16'h0301;
    #1;
    chk("wait_addr_held", mem_addr, 16'h0300);
    run(40);
    // store: d_rdata must keep the previous load value
    tick();
    d_we = 1; d_addr = 16'h0020; d_wdata = 24'h123456; d_req = 1;
    exp_d.push_back(d_model);
    tick();
    chk("store_en", {mem_en, mem_we}, 2'b11);
    chk("store_addr", mem_addr, 16'h0020);
    chk("store_wdata", mem_wdata, 24'h123456);
    tick();
    tick();
    chk("store_no_done_early", d_done, 0);
    tick();
    chk("store_done", d_done, 1);
    d_req = 0;
    tick();
    chk("store_mem0020", mem[16'h0020], 24'h123456);
    // single fetch with exact timing
    d_we = 0; if_addr = 16'h0010; if_req = 1;
    exp_if.push_back(24'hABCDEF);
    #1;
    chk("fetch_stall_T", {stall, mem_en}, 2'b10);
    tick();
    chk("fetch_issue", {mem_en, mem_we, busy, stall}, 4'b1011);
    chk("fetch_addr", mem_addr, 16'h0010);
    tick();
    chk("fetch_T2", {mem_en, stall, if_done}, 3'b010);
    tick();
    chk("fetch_T3", {stall, if_done}, 2'b10);
    tick();
    chk("fetch_T4", {if_done, d_done, stall}, 3'b100);
    if_req = 0;
    tick();
    chk("fetch_T5", {busy, stall, if_done}, 0);
    // both held continuously: grants alternate data/fetch
    en_cyc.delete();
    en_addr.delete();
    if_addr = 16'h0100; d_addr = 16'h0200; if_req = 1; d_req = 1;
    repeat (2) begin
      exp_d.push_back(24'h5A0200);
      exp_if.push_back(24'h5A0100);
    end
    nd = 0;
    for (int i = 0; i < 60 && nd < 4; i++) begin
      tick();
      if (if_done || d_done) nd++;
      if (nd == 4) begin
        if_req = 0;
        d_req = 0;
      end
    end
    chk("alt_dones", nd, 4);
    tick();
    chk("alt_grants", en_cyc.size(), 4);
    for (int i = 0; i < 4 && i < en_cyc.size(); i++) begin
      chk("alt_order", en_addr[i], (i % 2 == 0) ? 16'h0200 : 16'h0100);
      if (i > 0) chk("alt_period", en_cyc[i] - en_cyc[i-1], LAT + 3);
    end
    // reset during WAIT abandons the access
    if_addr = 16'h0500; d_addr = 16'h0600; if_req = 1; d_req = 1;
    tick();
    tick();
    rst = 0;
    #1;
    chk("midrst_ctrl", {busy, mem_en, if_done, d_done}, 0);
    chk("midrst_addr", mem_addr, 0);
    tick();
    chk("midrst_no_done", {if_done, d_done, busy}, 0);
    rst = 1;
    exp_d.push_back(24'h5A0600);
    exp_if.push_back(24'h5A0500);
    tick();
    chk("rearb_en", mem_en, 1);
    chk("rearb_addr", mem_addr, 16'h0600);
    run(40);
    tick();
    chk("sb_empty", {32'(exp_if.size()), 32'(exp_d.size())}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
